// File: rtl/rdma_rc_rx_ack.sv
// rtl/rdma_rc_rx_ack.sv - RC receive-side PSN checker and ACK/NAK generator (optional counters: RDMA_RX_STATS_EN)
module rdma_rc_rx_ack #(
   parameter logic [23:0] LOCAL_QPN  = 24'h000011,
   parameter logic [23:0] REMOTE_QPN = 24'h000022,
   parameter int          MAX_BEATS  = 512
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid,
   input  logic [63:0] rx_data,
   input  logic        rx_last,
   output logic        tx_valid,
   output logic [63:0] tx_data,
   output logic        tx_last,
   output logic [23:0] epsn,
   output logic [31:0] stat_ok,
   output logic [31:0] stat_dup,
   output logic [31:0] stat_oos,
   output logic [31:0] stat_drop
);

   localparam logic [7:0] OP_FIRST  = 8'h00;
   localparam logic [7:0] OP_MIDDLE = 8'h01;
   localparam logic [7:0] OP_LAST   = 8'h02;
   localparam logic [7:0] OP_ONLY   = 8'h04;
   localparam logic [7:0] RESP_OP   = 8'h11;
   localparam logic [7:0] SYN_ACK   = 8'h00;
   localparam logic [7:0] SYN_NAK   = 8'h60;
   localparam int         CNT_W     = $clog2(MAX_BEATS + 1) + 1;

   typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_DROP} state_t;

   state_t             state, state_nxt;
   logic [23:0]        epsn_r;
   logic               nak_pending;
   logic [CNT_W-1:0]   beat_cnt;
   logic [7:0]         pkt_op;
   logic               pkt_ackreq;
   logic [23:0]        pkt_psn;

   // header field views of the current beat
   logic [7:0]         hdr_op;
   logic [23:0]        hdr_qp;
   logic               hdr_ackreq;
   logic [23:0]        hdr_psn;
   logic               unused_hdr_bits;

   assign hdr_op          = rx_data[63:56];
   assign hdr_qp          = rx_data[55:32];
   assign hdr_ackreq      = rx_data[31];
   assign hdr_psn         = rx_data[23:0];
   assign unused_hdr_bits = ^rx_data[30:24];

   // decode results
   logic               is_hdr;
   logic               hdr_ok;
   logic               payload_beat;
   logic               overflow;
   logic               commit;
   logic [7:0]         c_op;
   logic               c_ackreq;
   logic [23:0]        c_psn;
   logic [23:0]        psn_dist;
   logic               in_order;
   logic               dup;
   logic               oos;
   logic               send_ack;
   logic               send_nak;
   logic [23:0]        resp_psn;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // next-state: any rx_last beat returns to IDLE, bad header or overflow parks in DROP
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (rx_valid) begin
               if (rx_last)      state_nxt = S_IDLE;
               else if (!hdr_ok) state_nxt = S_DROP;
               else              state_nxt = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            if (rx_valid) begin
               if (rx_last)       state_nxt = S_IDLE;
               else if (overflow) state_nxt = S_DROP;
            end
         end
         S_DROP: begin
            if (rx_valid && rx_last) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // output decode: header check, PSN classification and response selection
   always_comb begin
      is_hdr       = (state == S_IDLE) && rx_valid;
      hdr_ok       = (hdr_qp == LOCAL_QPN) &&
                     (hdr_op == OP_FIRST || hdr_op == OP_MIDDLE ||
                      hdr_op == OP_LAST  || hdr_op == OP_ONLY);
      payload_beat = (state == S_PAYLOAD) && rx_valid;
      // beat_cnt holds payload beats already accepted; this beat would be one too many
      overflow     = payload_beat && (beat_cnt == CNT_W'(MAX_BEATS));
      commit       = (is_hdr && hdr_ok && rx_last) || (payload_beat && rx_last && !overflow);
      c_op         = is_hdr ? hdr_op     : pkt_op;
      c_ackreq     = is_hdr ? hdr_ackreq : pkt_ackreq;
      c_psn        = is_hdr ? hdr_psn    : pkt_psn;
      psn_dist     = c_psn - epsn_r;
      in_order     = (psn_dist == 24'd0);
      dup          = psn_dist[23];
      oos          = !in_order && !psn_dist[23];
      send_ack     = commit && ((in_order && (c_ackreq || c_op == OP_LAST || c_op == OP_ONLY)) || dup);
      send_nak     = commit && oos && !nak_pending;
      // ACK reports the last accepted PSN; for in-order that is the PSN being accepted now
      if (send_nak || in_order) resp_psn = epsn_r;
      else                      resp_psn = epsn_r - 24'd1;
   end

   // packet context: header fields and payload beat count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt   <= '0;
         pkt_op     <= 8'h00;
         pkt_ackreq <= 1'b0;
         pkt_psn    <= 24'd0;
      end else if (is_hdr) begin
         beat_cnt   <= '0;
         pkt_op     <= hdr_op;
         pkt_ackreq <= hdr_ackreq;
         pkt_psn    <= hdr_psn;
      end else if (payload_beat && !overflow) begin
         beat_cnt   <= beat_cnt + CNT_W'(1);
      end
   end

   // sequence state committed on the last beat of an accepted packet
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         epsn_r      <= 24'd0;
         nak_pending <= 1'b0;
      end else if (commit) begin
         if (in_order) begin
            epsn_r      <= epsn_r + 24'd1;
            nak_pending <= 1'b0;
         end else if (send_nak) begin
            nak_pending <= 1'b1;
         end
      end
   end

   // one-cycle registered response beat
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_valid <= 1'b0;
         tx_last  <= 1'b0;
         tx_data  <= 64'd0;
      end else begin
         tx_valid <= send_ack || send_nak;
         tx_last  <= send_ack || send_nak;
         if (send_nak)      tx_data <= {RESP_OP, REMOTE_QPN, SYN_NAK, resp_psn};
         else if (send_ack) tx_data <= {RESP_OP, REMOTE_QPN, SYN_ACK, resp_psn};
         else               tx_data <= 64'd0;
      end
   end

   assign epsn = epsn_r;

`ifdef RDMA_RX_STATS_EN
   logic [31:0] cnt_ok, cnt_dup, cnt_oos, cnt_drop;

   // saturating event counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_ok   <= 32'd0;
         cnt_dup  <= 32'd0;
         cnt_oos  <= 32'd0;
         cnt_drop <= 32'd0;
      end else begin
         if (commit && in_order && cnt_ok   != 32'hFFFF_FFFF) cnt_ok   <= cnt_ok   + 32'd1;
         if (commit && dup      && cnt_dup  != 32'hFFFF_FFFF) cnt_dup  <= cnt_dup  + 32'd1;
         if (commit && oos      && cnt_oos  != 32'hFFFF_FFFF) cnt_oos  <= cnt_oos  + 32'd1;
         if (((is_hdr && !hdr_ok) || overflow) && cnt_drop != 32'hFFFF_FFFF)
            cnt_drop <= cnt_drop + 32'd1;
      end
   end

   assign stat_ok   = cnt_ok;
   assign stat_dup  = cnt_dup;
   assign stat_oos  = cnt_oos;
   assign stat_drop = cnt_drop;
`else
   assign stat_ok   = 32'd0;
   assign stat_dup  = 32'd0;
   assign stat_oos  = 32'd0;
   assign stat_drop = 32'd0;
`endif

endmodule

// File: tb/tb_rdma_rc_rx_ack.sv
// tb/tb_rdma_rc_rx_ack.sv - randomized and directed bench for rdma_rc_rx_ack against a packet-level model
module tb_rdma_rc_rx_ack;

   localparam logic [23:0] LQ = 24'h000011;
   localparam logic [23:0] RQ = 24'h000022;
   localparam int          MB = 512;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_valid = 1'b0;
   logic [63:0] rx_data = 64'd0;
   logic        rx_last = 1'b0;
   logic        tx_valid, tx_last;
   logic [63:0] tx_data;
   logic [23:0] epsn;
   logic [31:0] stat_ok, stat_dup, stat_oos, stat_drop;

   always #5 clk = ~clk;

   rdma_rc_rx_ack #(.LOCAL_QPN(LQ), .REMOTE_QPN(RQ), .MAX_BEATS(MB)) dut (
      .clk(clk), .rst(rst),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_last(rx_last),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
      .epsn(epsn),
      .stat_ok(stat_ok), .stat_dup(stat_dup), .stat_oos(stat_oos), .stat_drop(stat_drop)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] st(input logic [31:0] v);
`ifdef RDMA_RX_STATS_EN
      return v;
`else
      return 32'd0 & v;
`endif
   endfunction

   function automatic logic [31:0] sat(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   function automatic logic [63:0] hdr(input logic [7:0] op, input logic [23:0] qp,
                                       input logic ar, input logic [23:0] psn);
      return {op, qp, ar, 7'd0, psn};
   endfunction

   // ---------------- packet-level reference model ----------------
   logic [23:0] m_epsn;
   bit          m_nak, m_in_pkt, m_dropped;
   int          m_nb;
   logic [7:0]  m_op;
   logic        m_ar;
   logic [23:0] m_psn;
   logic [31:0] m_ok, m_dup, m_oos, m_drop;
   bit          m_txv;
   logic [63:0] m_txd;

   task automatic m_send(input logic [7:0] syn, input logic [23:0] psn);
      m_txv = 1'b1;
      m_txd = {8'h11, RQ, syn, psn};
   endtask

   task automatic m_resolve();
      logic [23:0] d;
      d = m_psn - m_epsn;
      if (d == 24'd0) begin
         m_epsn = m_epsn + 24'd1;
         m_ok   = sat(m_ok);
         m_nak  = 1'b0;
         if (m_ar || m_op == 8'h02 || m_op == 8'h04) m_send(8'h00, m_epsn - 24'd1);
      end else if (d >= 24'h800000) begin
         m_dup = sat(m_dup);
         m_send(8'h00, m_epsn - 24'd1);
      end else begin
         m_oos = sat(m_oos);
         if (!m_nak) begin
            m_send(8'h60, m_epsn);
            m_nak = 1'b1;
         end
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_epsn = 24'd0; m_nak = 1'b0; m_in_pkt = 1'b0; m_dropped = 1'b0; m_nb = 0;
         m_ok = 32'd0; m_dup = 32'd0; m_oos = 32'd0; m_drop = 32'd0;
         m_txv = 1'b0; m_txd = 64'd0;
      end else begin
         m_txv = 1'b0;
         m_txd = 64'd0;
         if (rx_valid) begin
            if (!m_in_pkt) begin
               m_op  = rx_data[63:56];
               m_ar  = rx_data[31];
               m_psn = rx_data[23:0];
               m_nb  = 0;
               m_dropped = (rx_data[55:32] != LQ) ||
                           !(m_op == 8'h00 || m_op == 8'h01 || m_op == 8'h02 || m_op == 8'h04);
               if (m_dropped) m_drop = sat(m_drop);
               if (rx_last && !m_dropped) m_resolve();
               m_in_pkt = !rx_last;
            end else begin
               if (!m_dropped) begin
                  m_nb++;
                  if (m_nb > MB) begin
                     m_dropped = 1'b1;
                     m_drop    = sat(m_drop);
                  end
               end
               if (rx_last) begin
                  if (!m_dropped) m_resolve();
                  m_in_pkt = 1'b0;
               end
            end
         end
      end
   end

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         chk("tx_valid", {63'd0, tx_valid}, {63'd0, m_txv});
         chk("tx_last",  {63'd0, tx_last},  {63'd0, m_txv});
         chk("tx_data",  tx_data, m_txd);
         chk("epsn",     {40'd0, epsn}, {40'd0, m_epsn});
         chk("stat_ok",  {32'd0, stat_ok},   {32'd0, st(m_ok)});
         chk("stat_dup", {32'd0, stat_dup},  {32'd0, st(m_dup)});
         chk("stat_oos", {32'd0, stat_oos},  {32'd0, st(m_oos)});
         chk("stat_drop",{32'd0, stat_drop}, {32'd0, st(m_drop)});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic beat(input logic [63:0] d, input logic l);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = d;
      rx_last  = l;
   endtask

   task automatic idle();
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = {$urandom, $urandom};
      rx_last  = 1'($urandom_range(0, 1));
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      rx_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
      chk("rst_tx_data",  tx_data, 64'd0);
      chk("rst_tx_last",  {63'd0, tx_last}, 64'd0);
      chk("rst_epsn",     {40'd0, epsn}, 64'd0);
      chk("rst_stats",    {stat_ok | stat_dup, stat_oos | stat_drop}, 64'd0);
      rst = 1'b0;
   endtask

   task automatic set_epsn(input logic [23:0] v);
      @(posedge clk);
      #2;
      force dut.epsn_r = v;
      m_epsn = v;
      #1;
      release dut.epsn_r;
   endtask

   task automatic send_only(input logic [23:0] psn);
      beat(hdr(8'h04, LQ, 1'b0, psn), 1'b1);
      idle();
   endtask

   initial begin
      logic [7:0]  op;
      logic [23:0] qp, psn;
      int          np;

      do_reset();
      chk_en = 1'b1;

      // single-beat ONLY after reset
      send_only(24'd0);
      chk("s1_tx_valid", {63'd0, tx_valid}, 64'd1);
      chk("s1_tx_data",  tx_data, 64'h1100_0022_0000_0000);
      chk("s1_epsn",     {40'd0, epsn}, 64'd1);
      chk("s1_stat_ok",  {32'd0, stat_ok}, {32'd0, st(32'd1)});

      // FIRST with payload, then LAST
      do_reset();
      beat(hdr(8'h00, LQ, 1'b0, 24'd0), 1'b0);
      beat(64'hA, 1'b0);
      beat(64'hB, 1'b0);
      beat(64'hC, 1'b1);
      idle();
      chk("s2_first_no_tx", {63'd0, tx_valid}, 64'd0);
      chk("s2_first_epsn",  {40'd0, epsn}, 64'd1);
      beat(hdr(8'h02, LQ, 1'b0, 24'd1), 1'b1);
      idle();
      chk("s2_last_tx_data", tx_data, 64'h1100_0022_0000_0001);
      chk("s2_last_epsn",    {40'd0, epsn}, 64'd2);

      // out-of-sequence NAK once, then recovery
      do_reset();
      for (int i = 0; i < 5; i++) send_only(24'(i));
      chk("s3_epsn5", {40'd0, epsn}, 64'd5);
      send_only(24'd7);
      chk("s3_nak_valid", {63'd0, tx_valid}, 64'd1);
      chk("s3_nak_data",  tx_data, 64'h1100_0022_6000_0005);
      send_only(24'd7);
      chk("s3_second_silent", {63'd0, tx_valid}, 64'd0);
      chk("s3_stat_oos",      {32'd0, stat_oos}, {32'd0, st(32'd2)});
      send_only(24'd5);
      chk("s3_ack_data", tx_data, 64'h1100_0022_0000_0005);
      chk("s3_ack_epsn", {40'd0, epsn}, 64'd6);
      send_only(24'd8);
      chk("s3_nak_again", tx_data, 64'h1100_0022_6000_0006);

      // PSN wrap and duplicate
      do_reset();
      set_epsn(24'hFFFFFF);
      send_only(24'hFFFFFF);
      chk("s4_wrap_ack",  tx_data, 64'h1100_0022_00FF_FFFF);
      chk("s4_wrap_epsn", {40'd0, epsn}, 64'd0);
      send_only(24'hFFFFFF);
      chk("s4_dup_ack",  tx_data, 64'h1100_0022_00FF_FFFF);
      chk("s4_dup_epsn", {40'd0, epsn}, 64'd0);
      chk("s4_stat_dup", {32'd0, stat_dup}, {32'd0, st(32'd1)});

      // drops: wrong QP, bad opcode, payload overflow (ending on and past the limit)
      do_reset();
      beat(hdr(8'h04, 24'h000012, 1'b1, 24'd0), 1'b1);
      idle();
      chk("s5_qp_no_tx", {63'd0, tx_valid}, 64'd0);
      chk("s5_qp_drop",  {32'd0, stat_drop}, {32'd0, st(32'd1)});
      beat(hdr(8'h0A, LQ, 1'b1, 24'd0), 1'b1);
      idle();
      chk("s5_op_no_tx", {63'd0, tx_valid}, 64'd0);
      chk("s5_op_drop",  {32'd0, stat_drop}, {32'd0, st(32'd2)});
      beat(hdr(8'h04, LQ, 1'b0, 24'd0), 1'b0);
      for (int i = 1; i <= MB + 1; i++) beat({$urandom, $urandom}, 1'(i == MB + 1));
      idle();
      chk("s5_ovf_no_tx", {63'd0, tx_valid}, 64'd0);
      chk("s5_ovf_epsn",  {40'd0, epsn}, 64'd0);
      chk("s5_ovf_drop",  {32'd0, stat_drop}, {32'd0, st(32'd3)});
      beat(hdr(8'h04, LQ, 1'b0, 24'd0), 1'b0);
      for (int i = 1; i <= MB + 3; i++) beat({$urandom, $urandom}, 1'(i == MB + 3));
      idle();
      chk("s5_ovf2_drop", {32'd0, stat_drop}, {32'd0, st(32'd4)});
      beat(hdr(8'h04, LQ, 1'b0, 24'd0), 1'b0);
      for (int i = 1; i <= MB; i++) beat({$urandom, $urandom}, 1'(i == MB));
      idle();
      chk("s5_max_ack",  tx_data, 64'h1100_0022_0000_0000);
      chk("s5_max_epsn", {40'd0, epsn}, 64'd1);

      // reset during a multi-beat packet
      do_reset();
      beat(hdr(8'h04, LQ, 1'b1, 24'd0), 1'b0);
      beat(64'h1, 1'b0);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = 64'h2;
      rx_last  = 1'b0;
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("s6_rst_no_tx", {63'd0, tx_valid}, 64'd0);
      rst = 1'b0;
      rx_valid = 1'b0;
      send_only(24'd0);
      chk("s6_ack_data", tx_data, 64'h1100_0022_0000_0000);
      chk("s6_ack_epsn", {40'd0, epsn}, 64'd1);

      // randomized traffic checked every cycle by the model
      do_reset();
      for (int p = 0; p < 400; p++) begin
         case ($urandom_range(0, 11))
            0, 1, 2:  op = 8'h04;
            3, 4:     op = 8'h00;
            5, 6:     op = 8'h01;
            7, 8, 9:  op = 8'h02;
            10:       op = 8'h0A;
            default:  op = 8'(3 + $urandom_range(0, 1) * 4);
         endcase
         qp = ($urandom_range(0, 9) == 0) ? 24'h000012 : LQ;
         case ($urandom_range(0, 7))
            0, 1, 2, 3: psn = m_epsn;
            4:          psn = m_epsn + 24'd1;
            5:          psn = m_epsn + 24'd2;
            6:          psn = m_epsn - 24'd1;
            default:    psn = 24'($urandom);
         endcase
         np = $urandom_range(0, 4);
         beat(hdr(op, qp, 1'($urandom_range(0, 1)), psn), 1'(np == 0));
         for (int i = 1; i <= np; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            beat({$urandom, $urandom}, 1'(i == np));
         end
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle();
      end
      idle();
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
